// File: rtl/keypad_hex_entry_if.sv
// Keypad and display pins of keypad_hex_entry: row sense in, column drive,
// digit enables, segments and entered-value outputs.
interface keypad_hex_entry_if #(
  parameter int DIGITS = 4
);
  logic [3:0]          row;
  logic [3:0]          col;
  logic [DIGITS-1:0]   an;
  logic [6:0]          segs;
  logic                key_valid;
  logic [3:0]          key_val;
  logic [4*DIGITS-1:0] value;

  modport master (
    input  row,
    output col, an, segs, key_valid, key_val, value
  );

  modport slave (
    output row,
    input  col, an, segs, key_valid, key_val, value
  );
endinterface

// File: rtl/keypad_hex_entry.sv
// Purpose: 4x4 hex keypad scan + debounce, DIGITS-nibble entry shift register, muxed 7-seg display.
// Latency: key_valid on the frame-closing tick of the DEBOUNCE-th matching frame; display updates per refresh tick.
// Backpressure: none, free-running; KPD_LEADING_BLANK_EN blanks unentered leading digits.
module keypad_hex_entry #(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEBOUNCE    = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  keypad_hex_entry_if.master kp
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] DB = 4'(DEBOUNCE);
  localparam logic [DIGITS-1:0] AN_RST = ~(DIGITS'(1));

  typedef enum logic [1:0] {S_IDLE, S_DN, S_HELD, S_UP} state_t;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Row synchroniser; rows idle high through the pull-ups.
  logic [3:0] row_m, row_s;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= kp.row;
      row_s <= row_m;
    end
  end

  logic [SW-1:0] scan_cnt;
  logic          scan_tick;
  logic [1:0]    cidx;
  logic [3:0]    col_q;
  assign scan_tick = (scan_cnt == SW'(SCAN_DIV - 1));

  // Per-frame hit accumulation: acc_n counts low rows seen, saturating at 2 (ghost).
  logic [1:0] acc_n, samp_n, merged_n;
  logic [3:0] acc_key, samp_key, merged_key;
  logic [2:0] sum_n;

  always_comb begin
    samp_n   = 2'd0;
    samp_key = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s[r]) begin
        samp_key = key_code(2'(r), cidx);
        if (samp_n != 2'd2) samp_n = samp_n + 2'd1;
      end
    end
    sum_n      = {1'b0, acc_n} + {1'b0, samp_n};
    merged_n   = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    merged_key = (acc_n == 2'd1) ? acc_key : samp_key;
  end

  logic       frame_close, cand_vld;
  logic [3:0] cand;
  assign frame_close = scan_tick && (cidx == 2'd3);
  assign cand_vld    = (merged_n == 2'd1);
  assign cand        = merged_key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      cidx     <= 2'd0;
      col_q    <= 4'b1110;
      acc_n    <= 2'd0;
      acc_key  <= 4'h0;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
      if (scan_tick) begin
        cidx  <= cidx + 2'd1;
        col_q <= {col_q[2:0], col_q[3]};
        if (cidx == 2'd3) begin
          acc_n   <= 2'd0;
          acc_key <= 4'h0;
        end else begin
          acc_n   <= merged_n;
          acc_key <= merged_key;
        end
      end
    end
  end

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0] held, held_nxt;
  logic       accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      held  <= 4'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      held  <= held_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    held_nxt  = held;
    accept    = 1'b0;
    cnt_inc   = cnt + 4'd1;
    if (frame_close) begin
      case (state)
        S_IDLE: if (cand_vld) begin
          held_nxt = cand;
          cnt_nxt  = 4'd1;
          if (DB == 4'd1) begin
            state_nxt = S_HELD;
            accept    = 1'b1;
          end else begin
            state_nxt = S_DN;
          end
        end
        S_DN: begin
          if (cand_vld && cand == held) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc >= DB) begin
              state_nxt = S_HELD;
              accept    = 1'b1;
            end
          end else if (cand_vld) begin
            held_nxt = cand;
            cnt_nxt  = 4'd1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_HELD: if (!cand_vld) begin
          cnt_nxt   = 4'd1;
          state_nxt = (DB == 4'd1) ? S_IDLE : S_UP;
        end
        default: begin
          if (cand_vld) begin
            state_nxt = S_HELD;
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt_inc >= DB) state_nxt = S_IDLE;
          end
        end
      endcase
    end
  end

  logic                key_valid_q;
  logic [3:0]          key_val_q;
  logic [4*DIGITS-1:0] value_q;
  logic [4*DIGITS+3:0] shifted;
  logic [3:0]          ent;
  assign shifted = {value_q, held_nxt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_q <= 1'b0;
      key_val_q   <= 4'h0;
      value_q     <= '0;
      ent         <= 4'd0;
    end else begin
      key_valid_q <= accept;
      if (accept) begin
        key_val_q <= held_nxt;
        value_q   <= shifted[4*DIGITS-1:0];
        if (ent != 4'(DIGITS)) ent <= ent + 4'd1;
      end
    end
  end

  // Display refresh: an/segs are loaded together for the digit being switched to.
  logic [RW-1:0]     ref_cnt;
  logic              ref_tick;
  logic [DW-1:0]     dig, dig_nxt;
  logic [DIGITS-1:0] an_q, an_nxt;
  logic [6:0]        segs_q, segs_nxt;
  logic [3:0]        nib;
  logic              blank;

  assign ref_tick = (ref_cnt == RW'(REFRESH_DIV - 1));
  assign dig_nxt  = (dig == DW'(DIGITS - 1)) ? '0 : dig + 1'b1;
  assign nib      = value_q[{dig_nxt, 2'b00} +: 4];

  always_comb begin
    an_nxt = '1;
    for (int i = 0; i < DIGITS; i++) an_nxt[i] = (DW'(i) != dig_nxt);
  end

`ifdef KPD_LEADING_BLANK_EN
  assign blank = (4'(dig_nxt) >= ent) && (dig_nxt != '0);
`else
  assign blank = 1'b0;
`endif

  assign segs_nxt = blank ? 7'h7F : hex7(nib);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      dig     <= '0;
      an_q    <= AN_RST;
      segs_q  <= 7'h40;
    end else begin
      ref_cnt <= ref_tick ? '0 : ref_cnt + 1'b1;
      if (ref_tick) begin
        dig    <= dig_nxt;
        an_q   <= an_nxt;
        segs_q <= segs_nxt;
      end
    end
  end

  assign kp.col       = col_q;
  assign kp.an        = an_q;
  assign kp.segs      = segs_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_val   = key_val_q;
  assign kp.value     = value_q;

endmodule

// File: doc/keypad_hex_entry.md
# keypad_hex_entry

Parametrised keypad-entry and display block for the Anvyl board: scans a 4x4 hex keypad, debounces and edge-detects key presses, shifts each accepted hex digit into a DIGITS-wide entry register, and time-multiplexes that register onto a DIGITS-digit seven-segment display. It supersedes the single-digit keypad-to-segment top, integrating scan, debounce, digit buffer and refresh under one clock with no derived clocks.

## Interface
- DIGITS, 4: display digits and entry-register nibbles, legal 1..8
- SCAN_DIV, 50000: clk cycles per scan tick, >= 2
- DEBOUNCE, 4: consecutive identical scan frames required to accept a press or a release, 1..15
- REFRESH_DIV, 50000: clk cycles per display digit slot, >= 2
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- row  in  4  keypad rows, active-low (pulled up), asynchronous; double-flopped internally
- col  out  4  keypad column drive, active-low one-hot
- an  out  DIGITS  digit enables, active-low one-hot
- segs  out  7  segments {g,f,e,d,c,b,a}, active-low
- key_valid  out  1  one-cycle pulse per accepted press
- key_val  out  4  code of last accepted key, held
- value  out  4*DIGITS  entry register; nibble 0 is the rightmost digit

## Operation
- Key map (row r top-to-bottom, col c left-to-right): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D.
- Scanner: a tick fires every SCAN_DIV clks. On each tick, sample the synchronised row for the currently driven column, then advance col 1110 -> 1101 -> 1011 -> 0111 -> 1110. The column-3 sample closes a frame of 4 ticks.
- Frame result:
  - exactly one row bit low across the frame -> candidate = that key;
  - none low -> NONE;
  - two or more low -> NONE (ghost rejection).
- Debounce FSM, evaluated at frame close:
  - IDLE: candidate K -> DN (cnt=1, held=K).
  - DN: same K -> cnt++; on reaching DEBOUNCE -> HELD. Any other result -> IDLE, or DN with cnt=1 if it is a different key.
  - HELD: NONE -> UP (cnt=1); any key -> stay.
  - UP: NONE -> cnt++; on reaching DEBOUNCE -> IDLE. Any key -> HELD.
  - With DEBOUNCE=1, the IDLE->HELD and HELD->IDLE transitions take one frame.
- Entering HELD:
  - pulse key_valid for one clk;
  - set key_val = K;
  - shift value <= {value[4*DIGITS-5:0], K};
  - increment entered-count ent, saturating at DIGITS.
  - One event per press; no auto-repeat.
- Display:
  - Refresh tick every REFRESH_DIV clks advances digit index d = 0..DIGITS-1, then wraps to 0.
  - an[d] = 0, all others 1.
  - segs = encode(value[4d+3:4d]).
- Encode (hex, active-low gfedcba): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.

## Timing
- Reset values (asynchronous):
  - outputs: col=1110, an[0]=0 with all other an bits 1, segs=0x40, key_valid=0, key_val=0, value=0;
  - internal: ent=0, FSM IDLE, all dividers and indices 0.
- rst_n deassertion: the first scan tick and the first refresh tick occur SCAN_DIV and REFRESH_DIV clks later.
- Press latency: key_valid rises on the clk edge of the frame-closing tick of the DEBOUNCE-th matching frame. key_val, value and ent update on that same edge. key_val and value are stable from the following cycle.
- Outputs are registered; segs and an change together on the refresh-tick edge.
- Reset mid-operation: any press or hold is discarded. A key held through reset release is accepted once after DEBOUNCE frames, exactly like a new press.
- Scan and refresh tick collisions are independent and need no arbitration.

## Configuration
- KPD_LEADING_BLANK_EN defined: a digit d with d >= ent and d != 0 is blanked (segs=0x7F, an still asserted). Digit 0 always displays, so reset shows a single 0.
- Undefined: every digit always displays its nibble, showing leading zeros. ent is still maintained but does not affect outputs.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=4, DEBOUNCE=2, REFRESH_DIV=8. The keypad model drives row[r]=0 while col[c]=0 and key (r,c) is pressed.
- Reset: hold rst_n low, then release -> col=1110, an=1110, segs=0x40, value=0x0000, key_valid=0. Without the macro, all four digits show 0x40 over one refresh round.
- Press 5, 3, A, 7 (each held 4 frames, released 4 frames) -> four key_valid pulses; value=0x53A7. The scanned digits show 0x78, 0x08, 0x30, 0x12 for d=0..3.
- Fifth press E -> value=0x3A7E; ent stays saturated at 4.
- Bounce: key 9 present for 1 frame, absent 1, present 1 -> no key_valid, value unchanged. Holding 9 for 2 frames -> exactly one pulse, key_val=9.
- Ghost: keys 1 and 4 pressed together for 6 frames -> no key_valid. Releasing 4 -> one event with key_val=1.
- With KPD_LEADING_BLANK_EN: after the single press 6, d=0 shows 0x02 and d=1..3 show 0x7F. Asserting rst_n mid-hold -> the reset values above, then one event after 2 frames.
